// File: rtl/cayde_rf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cayde_rf_pkg
// Brief    : Shared types and constants for the cayde multi-port register file
// Revision : 1.0 - initial release
// ============================================================================
package cayde_rf_pkg;

    localparam int RV32I_NREGS  = 32;
    localparam int RV32E_NREGS  = 16;
    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE_CLR = 2'd0,
        CLEARING = 2'd1,
        READY    = 2'd2
    } rf_state_e;

endpackage
`default_nettype wire

// File: rtl/cayde_rf_rdport.sv
`default_nettype none
// ============================================================================
// Module   : cayde_rf_rdport
// Brief    : One register-file read port: array mux, write bypass, x0/clear mask
// Revision : 1.0 - initial release
// ============================================================================
module cayde_rf_rdport #(
    parameter  int XLEN   = 32,
    parameter  int NREGS  = 32,
    parameter  int NWR    = 1,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic [AW-1:0]         i_raddr,
    input  logic [NREGS*XLEN-1:0] i_regs,
    input  logic [NWR*AW-1:0]     i_waddr,
    input  logic [NWR*XLEN-1:0]   i_wdata,
    input  logic [NWR-1:0]        i_wen,
    input  logic                  i_force_zero,
    output logic [XLEN-1:0]       o_rdata
);

    logic [XLEN-1:0] w_rdata;

    always_comb begin
        w_rdata = i_regs[int'(i_raddr)*XLEN +: XLEN];
        // Ascending scan so the highest-index matching write port wins.
        if (BYPASS != 0) begin
            for (int p = 0; p < NWR; p++) begin
                if (i_wen[p] && (i_waddr[p*AW +: AW] == i_raddr)) begin
                    w_rdata = i_wdata[p*XLEN +: XLEN];
                end
            end
        end
        if (i_force_zero || (i_raddr == '0)) begin
            w_rdata = '0;
        end
    end

    assign o_rdata = w_rdata;

endmodule
`default_nettype wire

// File: rtl/cayde_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : cayde_regfile_mp
// Brief    : Parametrised multi-port integer register file with clear engine
// Revision : 1.0 - initial release
// ============================================================================
module cayde_regfile_mp
    import cayde_rf_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEFAULT,
    parameter  int NREGS  = RV32I_NREGS,
    parameter  int NRD    = 2,
    parameter  int NWR    = 1,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    raddr_i,
    output logic [NRD*XLEN-1:0]  rdata_o,
    input  logic [NWR*AW-1:0]    waddr_i,
    input  logic [NWR*XLEN-1:0]  wdata_i,
    input  logic [NWR-1:0]       wen_i,
    input  logic                 clr_req_i,
    output logic                 ready_o,
    output logic                 clr_busy_o
);

    localparam logic [AW-1:0] c_FIRST_IDX = AW'(1);
    localparam logic [AW-1:0] c_LAST_IDX  = AW'(NREGS - 1);

    rf_state_e             r_state;
    rf_state_e             w_state_nxt;
    logic [AW-1:0]         r_clr_idx;
    logic [XLEN-1:0]       r_regs [1:NREGS-1];
    logic                  w_ready;
    logic                  w_busy;
    logic [NWR-1:0]        w_wen_q;
    logic [NREGS*XLEN-1:0] w_regs_flat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEARING;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE_CLR: w_state_nxt = CLEARING;
            CLEARING: begin
                if (clr_req_i) begin
                    w_state_nxt = CLEARING;
                end else if (r_clr_idx == c_LAST_IDX) begin
                    w_state_nxt = READY;
                end else if (r_clr_idx == '0) begin
                    w_state_nxt = IDLE_CLR;
                end
            end
            READY: begin
                if (clr_req_i) begin
                    w_state_nxt = CLEARING;
                end
            end
            default: w_state_nxt = CLEARING;
        endcase
    end

    always_comb begin
        w_ready = 1'b0;
        w_busy  = 1'b0;
        case (r_state)
            READY:    w_ready = 1'b1;
            CLEARING: w_busy  = 1'b1;
            default:  ;
        endcase
    end

    assign ready_o    = w_ready;
    assign clr_busy_o = w_busy;

    // Index restarts at 1 on every entry into CLEARING and on any clear request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_idx <= c_FIRST_IDX;
        end else if ((w_state_nxt == CLEARING) && ((r_state != CLEARING) || clr_req_i)) begin
            r_clr_idx <= c_FIRST_IDX;
        end else if (r_state == CLEARING) begin
            r_clr_idx <= r_clr_idx + 1'b1;
        end
    end

    // Storage is never reset; the clear engine zeroes one entry per cycle.
    always_ff @(posedge clk) begin
        if (w_busy) begin
            if (r_clr_idx != '0) begin
                r_regs[r_clr_idx] <= '0;
            end
        end else if (w_ready) begin
            for (int p = 0; p < NWR; p++) begin
                if (wen_i[p] && (waddr_i[p*AW +: AW] != '0)) begin
                    r_regs[waddr_i[p*AW +: AW]] <= wdata_i[p*XLEN +: XLEN];
                end
            end
        end
    end

    generate
        for (genvar i = 0; i < NREGS; i++) begin : g_flat
            if (i == 0) begin : g_zero
                assign w_regs_flat[0 +: XLEN] = '0;
            end else begin : g_entry
                assign w_regs_flat[i*XLEN +: XLEN] = r_regs[i];
            end
        end
    endgenerate

    assign w_wen_q = wen_i & {NWR{w_ready}};

    generate
        for (genvar k = 0; k < NRD; k++) begin : g_rd
            cayde_rf_rdport #(
                .XLEN   (XLEN),
                .NREGS  (NREGS),
                .NWR    (NWR),
                .BYPASS (BYPASS)
            ) u_rdport (
                .i_raddr      (raddr_i[k*AW +: AW]),
                .i_regs       (w_regs_flat),
                .i_waddr      (waddr_i),
                .i_wdata      (wdata_i),
                .i_wen        (w_wen_q),
                .i_force_zero (w_busy),
                .o_rdata      (rdata_o[k*XLEN +: XLEN])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cayde_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_cayde_regfile_mp
// Brief    : Self-checking bench: RV32I no-bypass and RV32E bypass instances
// Revision : 1.0 - initial release
// ============================================================================
module tb_cayde_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus per instance d (0: 32 regs, BYPASS=0; 1: 16 regs, BYPASS=1), port p/k
    logic [1:0]  s_rst;
    logic [1:0]  s_clr;
    logic        s_wen   [2][2];
    logic [4:0]  s_waddr [2][2];
    logic [31:0] s_wdata [2][2];
    logic [4:0]  s_raddr [2][2];

    logic [9:0]  raddr0, waddr0;
    logic [7:0]  raddr1, waddr1;
    logic [63:0] wdata0, wdata1, rdata0, rdata1;
    logic [1:0]  wen0, wen1, rdy, bsy;
    logic [31:0] got [2][2];

    assign raddr0 = {s_raddr[0][1], s_raddr[0][0]};
    assign waddr0 = {s_waddr[0][1], s_waddr[0][0]};
    assign raddr1 = {s_raddr[1][1][3:0], s_raddr[1][0][3:0]};
    assign waddr1 = {s_waddr[1][1][3:0], s_waddr[1][0][3:0]};
    assign wdata0 = {s_wdata[0][1], s_wdata[0][0]};
    assign wdata1 = {s_wdata[1][1], s_wdata[1][0]};
    assign wen0   = {s_wen[0][1], s_wen[0][0]};
    assign wen1   = {s_wen[1][1], s_wen[1][0]};
    assign got[0][0] = rdata0[31:0];
    assign got[0][1] = rdata0[63:32];
    assign got[1][0] = rdata1[31:0];
    assign got[1][1] = rdata1[63:32];

    cayde_regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0)) u_dut0 (
        .clk(clk), .rst(s_rst[0]), .raddr_i(raddr0), .rdata_o(rdata0),
        .waddr_i(waddr0), .wdata_i(wdata0), .wen_i(wen0), .clr_req_i(s_clr[0]),
        .ready_o(rdy[0]), .clr_busy_o(bsy[0])
    );

    cayde_regfile_mp #(.XLEN(32), .NREGS(16), .NRD(2), .NWR(2), .BYPASS(1)) u_dut1 (
        .clk(clk), .rst(s_rst[1]), .raddr_i(raddr1), .rdata_o(rdata1),
        .waddr_i(waddr1), .wdata_i(wdata1), .wen_i(wen1), .clr_req_i(s_clr[1]),
        .ready_o(rdy[1]), .clr_busy_o(bsy[1])
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
        n_total++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, g, e);
        end
    endtask

    // Reference model: a clear request zeroes the architectural state at once and
    // then hides it for NREGS-1 cycles, during which reads are 0 and writes drop.
    int          nregs [2] = '{32, 16};
    bit          byp   [2] = '{1'b0, 1'b1};
    logic [31:0] m_regs [2][32];
    int          m_cnt  [2] = '{0, 0};
    bit          m_init [2] = '{1'b0, 1'b0};

    function automatic logic [31:0] exp_rd(int d, int k);
        logic [31:0] r;
        int a;
        a = int'(s_raddr[d][k]);
        if (m_cnt[d] > 0 || a == 0) return 32'h0;
        r = m_regs[d][a];
        if (byp[d]) begin
            for (int p = 0; p < 2; p++) begin
                if (s_wen[d][p] && int'(s_waddr[d][p]) == a) r = s_wdata[d][p];
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (s_rst[d]) begin
                m_init[d] = 1'b1;
                m_cnt[d]  = nregs[d] - 1;
                for (int i = 0; i < 32; i++) m_regs[d][i] = 32'h0;
            end else if (m_cnt[d] > 0) begin
                m_cnt[d] = s_clr[d] ? nregs[d] - 1 : m_cnt[d] - 1;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (s_wen[d][p] && s_waddr[d][p] != 5'd0)
                        m_regs[d][int'(s_waddr[d][p])] = s_wdata[d][p];
                end
                if (s_clr[d]) begin
                    m_cnt[d] = nregs[d] - 1;
                    for (int i = 0; i < 32; i++) m_regs[d][i] = 32'h0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (m_init[d]) begin
                chk($sformatf("ready d%0d", d), 32'(rdy[d]), 32'(m_cnt[d] == 0));
                chk($sformatf("busy d%0d", d), 32'(bsy[d]), 32'(m_cnt[d] > 0));
                for (int k = 0; k < 2; k++)
                    chk($sformatf("rdata d%0d k%0d a%0d", d, k, s_raddr[d][k]), got[d][k], exp_rd(d, k));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_clr = 2'b00;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                s_wen[d][p]   = 1'b0;
                s_waddr[d][p] = 5'd0;
                s_wdata[d][p] = 32'h0;
                s_raddr[d][p] = 5'd0;
            end
        end
    endtask

    initial begin
        idle_inputs();
        s_rst = 2'b11;
        step();
        s_rst = 2'b00;
        s_raddr[0][0] = 5'd5;
        s_raddr[1][0] = 5'd5;
        for (int i = 1; i <= 34; i++) begin
            @(negedge clk);
            if (i == 31) chk("rst ready d0 cyc31", 32'(rdy[0]), 32'd0);
            if (i == 32) chk("rst ready d0 cyc32", 32'(rdy[0]), 32'd1);
            if (i == 32) chk("rst x5 d0", got[0][0], 32'h0);
            if (i == 15) chk("rst ready d1 cyc15", 32'(rdy[1]), 32'd0);
            if (i == 16) chk("rst ready d1 cyc16", 32'(rdy[1]), 32'd1);
            step();
        end

        // Write x3 (d0, no bypass); bypass x7 and x0 discard (d1)
        s_wen[0][0] = 1'b1; s_waddr[0][0] = 5'd3; s_wdata[0][0] = 32'hDEADBEEF;
        s_raddr[0][0] = 5'd3; s_raddr[0][1] = 5'd3;
        s_wen[1][0] = 1'b1; s_waddr[1][0] = 5'd7; s_wdata[1][0] = 32'h12345678;
        s_wen[1][1] = 1'b1; s_waddr[1][1] = 5'd0; s_wdata[1][1] = 32'hFFFFFFFF;
        s_raddr[1][0] = 5'd7; s_raddr[1][1] = 5'd0;
        @(negedge clk);
        chk("x3 same cycle old", got[0][0], 32'h0);
        chk("x7 bypass", got[1][0], 32'h12345678);
        chk("x0 bypass zero", got[1][1], 32'h0);
        step();
        idle_inputs();
        s_raddr[0][0] = 5'd3; s_raddr[0][1] = 5'd3; s_raddr[1][1] = 5'd0;
        @(negedge clk);
        chk("x3 port0 next", got[0][0], 32'hDEADBEEF);
        chk("x3 port1 next", got[0][1], 32'hDEADBEEF);
        chk("x0 after write", got[1][1], 32'h0);
        step();

        // Collision on x10: port 1 wins
        for (int d = 0; d < 2; d++) begin
            s_wen[d][0] = 1'b1; s_waddr[d][0] = 5'd10; s_wdata[d][0] = 32'h1;
            s_wen[d][1] = 1'b1; s_waddr[d][1] = 5'd10; s_wdata[d][1] = 32'h2;
            s_raddr[d][0] = 5'd10;
        end
        @(negedge clk);
        chk("x10 collision bypass", got[1][0], 32'h2);
        step();
        idle_inputs();
        s_raddr[0][0] = 5'd10; s_raddr[1][0] = 5'd10;
        @(negedge clk);
        chk("x10 collision d0", got[0][0], 32'h2);
        chk("x10 collision d1", got[1][0], 32'h2);
        step();

        // Fill d0 then runtime clear, with an ignored write mid-clear
        for (int i = 1; i < 32; i++) begin
            s_wen[0][0] = 1'b1; s_waddr[0][0] = 5'(i); s_wdata[0][0] = 32'(i);
            step();
        end
        idle_inputs();
        s_raddr[0][0] = 5'd31; s_raddr[0][1] = 5'd17;
        @(negedge clk);
        chk("fill x31", got[0][0], 32'd31);
        chk("fill x17", got[0][1], 32'd17);
        s_clr[0] = 1'b1;
        step();
        s_clr[0] = 1'b0;
        s_wen[0][0] = 1'b1; s_waddr[0][0] = 5'd4; s_wdata[0][0] = 32'hAA;
        s_raddr[0][0] = 5'd4;
        @(negedge clk);
        chk("clr busy read x4", got[0][0], 32'h0);
        step();
        s_wen[0][0] = 1'b0;
        for (int i = 2; i <= 32; i++) begin
            @(negedge clk);
            if (i == 31) chk("clr ready cyc31", 32'(rdy[0]), 32'd0);
            if (i == 32) chk("clr ready cyc32", 32'(rdy[0]), 32'd1);
            if (i == 32) chk("clr x4 dropped", got[0][0], 32'h0);
            step();
        end
        for (int a = 0; a < 32; a += 2) begin
            s_raddr[0][0] = 5'(a); s_raddr[0][1] = 5'(a + 1);
            step();
        end

        // d1: reset while clear index is 9
        s_clr[1] = 1'b1;
        step();
        s_clr[1] = 1'b0;
        repeat (8) step();
        s_rst[1] = 1'b1;
        step();
        s_rst[1] = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            if (i == 15) chk("midclr rst ready cyc15", 32'(rdy[1]), 32'd0);
            if (i == 16) chk("midclr rst ready cyc16", 32'(rdy[1]), 32'd1);
            step();
        end

        // Randomized traffic, checked by the model every cycle
        for (int c = 0; c < 2500; c++) begin
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    s_wen[d][p]   = 1'($urandom_range(0, 1));
                    s_waddr[d][p] = 5'($urandom_range(0, nregs[d] - 1));
                    s_wdata[d][p] = $urandom;
                    s_raddr[d][p] = 5'($urandom_range(0, nregs[d] - 1));
                    if ($urandom_range(0, 3) == 0)
                        s_raddr[d][p] = s_waddr[d][$urandom_range(0, 1)];
                end
                s_clr[d] = ($urandom_range(0, 79) == 0);
                s_rst[d] = ($urandom_range(0, 299) == 0);
            end
            step();
        end
        idle_inputs();
        s_rst = 2'b00;
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
